depp_host: RTL and testbench
============================

DEPP_HOST -- requirements
Module: depp_host

Interface
REQ-001 Parameter SETUP_CYCLES, default 2, clocks of write_n/data setup before strobe assertion (range 1..15).
REQ-002 Parameter TIMEOUT_CYCLES, default 255, max clocks waiting on each i_wait edge (range 1..65535).
REQ-003 i_clk  in  1  sole clock; all state on rising edge.
REQ-004 i_rst  in  1  reset, asynchronous, active-high.
REQ-005 i_cmd_stb  in  1  command request; accepted when o_cmd_busy=0.
REQ-006 i_cmd_op  in  2  00 addr write, 01 data write, 10 addr read, 11 data read.
REQ-007 i_cmd_data  in  8  write byte; ignored for reads.
REQ-008 o_cmd_busy  out  1  high from accept through o_rsp_stb cycle.
REQ-009 o_rsp_stb  out  1  one-cycle completion pulse.
REQ-010 o_rsp_data  out  8  read byte; holds value until next read completes.
REQ-011 o_rsp_err  out  1  valid with o_rsp_stb; 1 = timeout.
REQ-012 o_astb_n, o_dstb_n, o_write_n  out  1 each  EPP strobes, active-low.
REQ-013 o_depp  out  8  EPP bus drive value; o_depp_oe  out  1  bus drive enable.
REQ-014 i_depp  in  8  EPP bus sampled value; i_wait  in  1  peripheral wait, asynchronous.

Function
REQ-015 i_wait SHALL pass a 2-flop synchronizer; all decisions use synchronized wait_s.
REQ-016 States: IDLE, SETUP, STROBE, RELEASE, DONE.
REQ-017 IDLE: strobes and write_n high, oe low; i_cmd_stb with wait_s=0 latches op/data, enters SETUP next cycle.
REQ-018 i_cmd_stb while busy SHALL be ignored (no queueing).
REQ-019 SETUP: write_n low and oe high for writes, write_n high and oe low for reads, o_depp = latched byte; lasts exactly SETUP_CYCLES clocks.
REQ-020 STROBE: selected strobe (astb for ops 00/10, dstb for 01/11) low; remain until wait_s=1.
REQ-021 On wait_s=1 in STROBE for reads, o_rsp_data SHALL capture i_depp in the same clock.
REQ-022 RELEASE: strobe high, write_n and oe held; remain until wait_s=0, then DONE.
REQ-023 DONE: single cycle; o_rsp_stb=1, write_n high, oe low; next state IDLE; o_cmd_busy=0 in the following cycle.
REQ-024 Only one strobe SHALL ever be low; oe SHALL never be high while write_n is high.
REQ-025 Command latency with immediate peripheral response: SETUP_CYCLES + 2 synchronizer cycles per wait edge + 1 DONE cycle.
REQ-026 Command arriving while wait_s=1 in IDLE SHALL be held off (busy stays 0, command not accepted) until wait_s=0.

Reset
REQ-027 Asynchronous assert: state IDLE, o_astb_n=o_dstb_n=o_write_n=1, o_depp_oe=0, o_depp=0, o_cmd_busy=0, o_rsp_stb=0, o_rsp_err=0, o_rsp_data=0, synchronizer flops=0, counters=0.
REQ-028 Reset mid-cycle SHALL release strobes immediately and discard the command with no o_rsp_stb.

Configuration
REQ-029 Macro DEPP_HOST_TIMEOUT_EN defined: counter resets on entering STROBE and RELEASE; reaching TIMEOUT_CYCLES forces strobes high, oe low, DONE with o_rsp_err=1; read data not captured.
REQ-030 Macro absent: no counter logic, STROBE/RELEASE wait indefinitely, o_rsp_err tied 0.

Structure
REQ-031 Shared package depp_pkg: op codes (DEPP_OP_AWR=00, DEPP_OP_DWR=01, DEPP_OP_ARD=10, DEPP_OP_DRD=11), state encoding, default SETUP/TIMEOUT constants.
REQ-032 One sub-module: depp_sync2 (2-flop synchronizer, async active-high reset), instanced on i_wait.
REQ-033 Total RTL 120-400 lines.

Verification
REQ-034 Addr write 0x05, peripheral model raising wait 1 clk after astb_n low -> o_depp=0x05, oe=1, astb_n low until wait_s=1, one o_rsp_stb, o_rsp_err=0.
REQ-035 Data read, model drives i_depp=0xA7 with wait -> o_rsp_data=0xA7, write_n high and oe low throughout.
REQ-036 Four back-to-back data writes 0x11,0x22,0x33,0x44 each issued as busy drops -> four o_rsp_stb pulses, bytes in order, dstb_n never low while wait_s=1 at entry.
REQ-037 TIMEOUT_EN, TIMEOUT_CYCLES=16, wait never asserted -> strobe released after 16 clocks in STROBE, o_rsp_stb with o_rsp_err=1.
REQ-038 i_rst pulsed while dstb_n low -> outputs to reset values asynchronously, no o_rsp_stb, next command completes normally.
REQ-039 i_cmd_stb during busy with different data -> ignored; only original command appears on bus.

Source files
------------

// File: rtl/depp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | depp_pkg : op codes, FSM state encoding and defaults for depp_host    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package depp_pkg;

  localparam logic [1:0] DEPP_OP_AWR = 2'b00;
  localparam logic [1:0] DEPP_OP_DWR = 2'b01;
  localparam logic [1:0] DEPP_OP_ARD = 2'b10;
  localparam logic [1:0] DEPP_OP_DRD = 2'b11;

  localparam int DEPP_SETUP_DEFAULT   = 2;
  localparam int DEPP_TIMEOUT_DEFAULT = 255;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } depp_state_t;

  // Bit 1 of the op selects read, bit 0 selects the data strobe.
  function automatic logic op_is_write(input logic [1:0] op);
    return ~op[1];
  endfunction

  function automatic logic op_is_data(input logic [1:0] op);
    return op[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/depp_sync2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | depp_sync2 : two-flop synchronizer, asynchronous active-high reset    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module depp_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= 2'b00;
    else       r_sync <= {r_sync[0], i_d};
  end

  assign o_q = r_sync[1];

endmodule
`default_nettype wire

// File: rtl/depp_host.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | depp_host : EPP host sequencer (address/data read/write cycles)       |
// | Optional wait timeout: define DEPP_HOST_TIMEOUT_EN.   Rev 1.0         |
// +----------------------------------------------------------------------+
module depp_host
  import depp_pkg::*;
#(
  parameter int SETUP_CYCLES   = DEPP_SETUP_DEFAULT,
  parameter int TIMEOUT_CYCLES = DEPP_TIMEOUT_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_stb,
  input  logic [1:0] i_cmd_op,
  input  logic [7:0] i_cmd_data,
  output logic       o_cmd_busy,
  output logic       o_rsp_stb,
  output logic [7:0] o_rsp_data,
  output logic       o_rsp_err,
  output logic       o_astb_n,
  output logic       o_dstb_n,
  output logic       o_write_n,
  output logic [7:0] o_depp,
  output logic       o_depp_oe,
  input  logic [7:0] i_depp,
  input  logic       i_wait
);

  // Out-of-range parameters select this empty branch; nothing is built for them.
  generate
    if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_range_bad
    end
  endgenerate

  logic        w_wait_s;
  depp_state_t r_state;
  logic [1:0]  r_op;
  logic [3:0]  r_setup_cnt;
  logic        r_busy, r_rsp_stb, r_astb_n, r_dstb_n, r_write_n, r_oe;
  logic [7:0]  r_depp, r_rsp_data;

  depp_sync2 u_wait_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_wait),
    .o_q   (w_wait_s)
  );

`ifdef DEPP_HOST_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;
  logic        r_rsp_err;
  logic        w_tmo;
  assign w_tmo     = (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign o_rsp_err = r_rsp_err;
`else
  assign o_rsp_err = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_op        <= 2'b00;
      r_setup_cnt <= 4'd0;
      r_busy      <= 1'b0;
      r_rsp_stb   <= 1'b0;
      r_astb_n    <= 1'b1;
      r_dstb_n    <= 1'b1;
      r_write_n   <= 1'b1;
      r_oe        <= 1'b0;
      r_depp      <= 8'h00;
      r_rsp_data  <= 8'h00;
`ifdef DEPP_HOST_TIMEOUT_EN
      r_tmo_cnt   <= 16'd0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_rsp_stb <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_cmd_stb && !w_wait_s) begin
            r_op        <= i_cmd_op;
            r_depp      <= i_cmd_data;
            r_write_n   <= ~op_is_write(i_cmd_op);
            r_oe        <= op_is_write(i_cmd_op);
            r_busy      <= 1'b1;
            r_setup_cnt <= 4'd0;
            r_state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_setup_cnt == 4'(SETUP_CYCLES - 1)) begin
            if (op_is_data(r_op)) r_dstb_n <= 1'b0;
            else                  r_astb_n <= 1'b0;
`ifdef DEPP_HOST_TIMEOUT_EN
            r_tmo_cnt <= 16'd0;
`endif
            r_state <= ST_STROBE;
          end else begin
            r_setup_cnt <= r_setup_cnt + 4'd1;
          end
        end
        ST_STROBE: begin
          if (w_wait_s) begin
            r_astb_n <= 1'b1;
            r_dstb_n <= 1'b1;
            if (!op_is_write(r_op)) r_rsp_data <= i_depp;
`ifdef DEPP_HOST_TIMEOUT_EN
            r_tmo_cnt <= 16'd0;
`endif
            r_state <= ST_RELEASE;
          end
`ifdef DEPP_HOST_TIMEOUT_EN
          else if (w_tmo) begin
            r_astb_n  <= 1'b1;
            r_dstb_n  <= 1'b1;
            r_write_n <= 1'b1;
            r_oe      <= 1'b0;
            r_rsp_stb <= 1'b1;
            r_rsp_err <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
          end
`endif
        end
        ST_RELEASE: begin
          if (!w_wait_s) begin
            r_write_n <= 1'b1;
            r_oe      <= 1'b0;
            r_rsp_stb <= 1'b1;
`ifdef DEPP_HOST_TIMEOUT_EN
            r_rsp_err <= 1'b0;
`endif
            r_state   <= ST_DONE;
          end
`ifdef DEPP_HOST_TIMEOUT_EN
          else if (w_tmo) begin
            r_write_n <= 1'b1;
            r_oe      <= 1'b0;
            r_rsp_stb <= 1'b1;
            r_rsp_err <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
          end
`endif
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_cmd_busy = r_busy;
  assign o_rsp_stb  = r_rsp_stb;
  assign o_rsp_data = r_rsp_data;
  assign o_astb_n   = r_astb_n;
  assign o_dstb_n   = r_dstb_n;
  assign o_write_n  = r_write_n;
  assign o_depp     = r_depp;
  assign o_depp_oe  = r_oe;

endmodule
`default_nettype wire

// File: tb/tb_depp_host.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_depp_host : directed self-checking bench for depp_host             |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_depp_host;
  import depp_pkg::*;

  localparam int SETUP = 3;
  localparam int TMO   = 16;

  logic       i_clk = 1'b0;
  logic       i_rst, i_cmd_stb, i_wait;
  logic [1:0] i_cmd_op;
  logic [7:0] i_cmd_data, i_depp;
  logic       o_cmd_busy, o_rsp_stb, o_rsp_err, o_astb_n, o_dstb_n, o_write_n, o_depp_oe;
  logic [7:0] o_rsp_data, o_depp;

  int n_cmp = 0;
  int n_err = 0;

  logic model_en = 1'b0;
  int   viol_both = 0, viol_oe = 0, viol_entry = 0;
  logic prev_a = 1'b1, prev_d = 1'b1, prev_wait = 1'b0;

  // Results of the most recent run_cmd
  int         r_busy_n, r_setup_n, r_astb_n, r_dstb_n, r_rsp_n;
  logic [7:0] r_strb_depp;
  logic       r_strb_oe, r_strb_wn, r_wn_low, r_oe_hi, r_err;

  depp_host #(.SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cmd_stb(i_cmd_stb), .i_cmd_op(i_cmd_op),
    .i_cmd_data(i_cmd_data), .o_cmd_busy(o_cmd_busy), .o_rsp_stb(o_rsp_stb),
    .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err), .o_astb_n(o_astb_n),
    .o_dstb_n(o_dstb_n), .o_write_n(o_write_n), .o_depp(o_depp),
    .o_depp_oe(o_depp_oe), .i_depp(i_depp), .i_wait(i_wait)
  );

  always #5 i_clk = ~i_clk;

  // Peripheral: raises wait one clock after seeing a strobe low, drops it after release.
  always @(posedge i_clk) begin
    #1;
    if (model_en) i_wait = (!o_astb_n || !o_dstb_n);
  end

  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (!o_astb_n && !o_dstb_n) viol_both++;
      if (o_depp_oe && o_write_n) viol_oe++;
      if (((!o_astb_n && prev_a) || (!o_dstb_n && prev_d)) && prev_wait) viol_entry++;
    end
    prev_a = o_astb_n;
    prev_d = o_dstb_n;
    prev_wait = i_wait;
  end

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] data, input bit inject,
                         input logic [7:0] inj_data, input int budget);
    bit strobed = 0;
    bit done = 0;
    int guard = 0;
    r_busy_n = 0; r_setup_n = 0; r_astb_n = 0; r_dstb_n = 0; r_rsp_n = 0;
    r_strb_depp = 8'h00; r_strb_oe = 0; r_strb_wn = 1; r_wn_low = 0; r_oe_hi = 0; r_err = 0;
    while (o_cmd_busy && guard < budget) begin @(negedge i_clk); guard++; end
    i_cmd_stb = 1'b1; i_cmd_op = op; i_cmd_data = data;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge i_clk);
      if (c == 0) i_cmd_stb = 1'b0;
      if (inject && c == 1) begin i_cmd_stb = 1'b1; i_cmd_op = DEPP_OP_DWR; i_cmd_data = inj_data; end
      if (inject && c == 2) i_cmd_stb = 1'b0;
      if (o_cmd_busy) r_busy_n++;
      if (!o_astb_n) r_astb_n++;
      if (!o_dstb_n) r_dstb_n++;
      if (!strobed && (!o_astb_n || !o_dstb_n)) begin
        strobed = 1; r_strb_depp = o_depp; r_strb_oe = o_depp_oe; r_strb_wn = o_write_n;
      end
      if (!strobed && o_cmd_busy) r_setup_n++;
      if (!o_write_n) r_wn_low = 1;
      if (o_depp_oe) r_oe_hi = 1;
      if (o_rsp_stb) begin r_rsp_n++; r_err = o_rsp_err; done = 1; end
    end
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_cmd_stb = 1'b0; i_cmd_op = 2'b00; i_cmd_data = 8'h00;
    i_depp = 8'h00; i_wait = 1'b0;
    repeat (3) @(negedge i_clk);
    n_cmp++; if (o_astb_n !== 1'b1) begin n_err++; $display("FAIL reset_astb: got %b want 1", o_astb_n); end
    n_cmp++; if (o_dstb_n !== 1'b1) begin n_err++; $display("FAIL reset_dstb: got %b want 1", o_dstb_n); end
    n_cmp++; if (o_write_n !== 1'b1) begin n_err++; $display("FAIL reset_write_n: got %b want 1", o_write_n); end
    n_cmp++; if (o_depp_oe !== 1'b0) begin n_err++; $display("FAIL reset_oe: got %b want 0", o_depp_oe); end
    n_cmp++; if (o_depp !== 8'h00) begin n_err++; $display("FAIL reset_depp: got %h want 00", o_depp); end
    n_cmp++; if (o_cmd_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", o_cmd_busy); end
    n_cmp++; if ({o_rsp_stb, o_rsp_err} !== 2'b00) begin n_err++; $display("FAIL reset_rsp: got %b want 00", {o_rsp_stb, o_rsp_err}); end
    n_cmp++; if (o_rsp_data !== 8'h00) begin n_err++; $display("FAIL reset_rsp_data: got %h want 00", o_rsp_data); end
    i_rst = 1'b0;
    model_en = 1'b1;
    repeat (2) @(negedge i_clk);
  endtask

  task automatic test_addr_write;
    i_depp = 8'h00;
    run_cmd(DEPP_OP_AWR, 8'h05, 1'b0, 8'h00, 60);
    n_cmp++; if (r_rsp_n !== 1) begin n_err++; $display("FAIL awr_rsp_count: got %0d want 1", r_rsp_n); end
    n_cmp++; if (r_err !== 1'b0) begin n_err++; $display("FAIL awr_err: got %b want 0", r_err); end
    n_cmp++; if (r_strb_depp !== 8'h05) begin n_err++; $display("FAIL awr_depp: got %h want 05", r_strb_depp); end
    n_cmp++; if ({r_strb_oe, r_strb_wn} !== 2'b10) begin n_err++; $display("FAIL awr_oe_wn: got %b want 10", {r_strb_oe, r_strb_wn}); end
    n_cmp++; if (r_setup_n !== SETUP) begin n_err++; $display("FAIL awr_setup_len: got %0d want %0d", r_setup_n, SETUP); end
    n_cmp++; if ({r_astb_n, r_dstb_n} !== {32'd3, 32'd0}) begin n_err++; $display("FAIL awr_strobe_len: got a=%0d d=%0d want a=3 d=0", r_astb_n, r_dstb_n); end
    n_cmp++; if (r_busy_n !== 10) begin n_err++; $display("FAIL awr_busy_len: got %0d want 10", r_busy_n); end
    @(negedge i_clk);
    n_cmp++; if ({o_cmd_busy, o_rsp_stb} !== 2'b00) begin n_err++; $display("FAIL awr_after_done: got %b want 00", {o_cmd_busy, o_rsp_stb}); end
  endtask

  task automatic test_data_read;
    i_depp = 8'hA7;
    run_cmd(DEPP_OP_DRD, 8'h3C, 1'b0, 8'h00, 60);
    n_cmp++; if (r_rsp_n !== 1) begin n_err++; $display("FAIL drd_rsp_count: got %0d want 1", r_rsp_n); end
    n_cmp++; if (o_rsp_data !== 8'hA7) begin n_err++; $display("FAIL drd_data: got %h want a7", o_rsp_data); end
    n_cmp++; if ({r_wn_low, r_oe_hi} !== 2'b00) begin n_err++; $display("FAIL drd_bus_dir: got wn_low/oe %b want 00", {r_wn_low, r_oe_hi}); end
    n_cmp++; if ({r_astb_n, r_dstb_n} !== {32'd0, 32'd3}) begin n_err++; $display("FAIL drd_strobe_len: got a=%0d d=%0d want a=0 d=3", r_astb_n, r_dstb_n); end
    i_depp = 8'h00;
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 4; k++) begin
      run_cmd(DEPP_OP_DWR, bytes[k], 1'b0, 8'h00, 60);
      n_cmp++; if (r_rsp_n !== 1) begin n_err++; $display("FAIL b2b_rsp_%0d: got %0d want 1", k, r_rsp_n); end
      n_cmp++; if (r_strb_depp !== bytes[k]) begin n_err++; $display("FAIL b2b_byte_%0d: got %h want %h", k, r_strb_depp, bytes[k]); end
      n_cmp++; if (r_dstb_n !== 3) begin n_err++; $display("FAIL b2b_dstb_len_%0d: got %0d want 3", k, r_dstb_n); end
    end
    n_cmp++; if (o_rsp_data !== 8'hA7) begin n_err++; $display("FAIL b2b_rsp_data_kept: got %h want a7", o_rsp_data); end
  endtask

  task automatic test_ignore_busy;
    int extra_busy = 0;
    run_cmd(DEPP_OP_AWR, 8'h5A, 1'b1, 8'hC3, 60);
    n_cmp++; if (r_strb_depp !== 8'h5A) begin n_err++; $display("FAIL ign_depp: got %h want 5a", r_strb_depp); end
    n_cmp++; if ({r_astb_n, r_dstb_n} !== {32'd3, 32'd0}) begin n_err++; $display("FAIL ign_strobes: got a=%0d d=%0d want a=3 d=0", r_astb_n, r_dstb_n); end
    n_cmp++; if (r_rsp_n !== 1) begin n_err++; $display("FAIL ign_rsp_count: got %0d want 1", r_rsp_n); end
    repeat (6) begin @(negedge i_clk); if (o_cmd_busy) extra_busy++; end
    n_cmp++; if (extra_busy !== 0) begin n_err++; $display("FAIL ign_no_queue: got %0d busy cycles want 0", extra_busy); end
  endtask

  task automatic test_wait_holdoff;
    int busy_seen = 0;
    int lat = 0;
    bit rsp = 0;
    model_en = 1'b0;
    @(negedge i_clk); i_wait = 1'b1;
    repeat (3) @(negedge i_clk);
    i_cmd_stb = 1'b1; i_cmd_op = DEPP_OP_DWR; i_cmd_data = 8'h77;
    repeat (4) begin @(negedge i_clk); if (o_cmd_busy) busy_seen++; end
    n_cmp++; if (busy_seen !== 0) begin n_err++; $display("FAIL hold_busy: got %0d busy cycles want 0", busy_seen); end
    i_wait = 1'b0; model_en = 1'b1;
    while (!o_cmd_busy && lat < 10) begin @(negedge i_clk); lat++; end
    i_cmd_stb = 1'b0;
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL hold_accept_latency: got %0d want 3", lat); end
    for (int c = 0; c < 40 && !rsp; c++) begin @(negedge i_clk); if (o_rsp_stb) rsp = 1; end
    n_cmp++; if (rsp !== 1'b1) begin n_err++; $display("FAIL hold_complete: got %b want 1", rsp); end
  endtask

  task automatic test_reset_mid_strobe;
    int guard = 0;
    int rsp_cnt = 0;
    model_en = 1'b0; i_wait = 1'b0; i_depp = 8'h00;
    @(negedge i_clk);
    i_cmd_stb = 1'b1; i_cmd_op = DEPP_OP_DWR; i_cmd_data = 8'h99;
    @(negedge i_clk); i_cmd_stb = 1'b0;
    while (o_dstb_n && guard < 20) begin @(negedge i_clk); guard++; end
    n_cmp++; if (o_dstb_n !== 1'b0) begin n_err++; $display("FAIL rst_mid_reach_strobe: got %b want 0", o_dstb_n); end
    #2 i_rst = 1'b1;
    #1;
    n_cmp++; if ({o_dstb_n, o_write_n, o_depp_oe, o_cmd_busy} !== 4'b1100) begin n_err++; $display("FAIL rst_mid_async: got %b want 1100", {o_dstb_n, o_write_n, o_depp_oe, o_cmd_busy}); end
    n_cmp++; if ({o_depp, o_rsp_data} !== 16'h0000) begin n_err++; $display("FAIL rst_mid_data: got %h want 0000", {o_depp, o_rsp_data}); end
    @(negedge i_clk); i_rst = 1'b0;
    repeat (5) begin @(negedge i_clk); if (o_rsp_stb) rsp_cnt++; end
    n_cmp++; if (rsp_cnt !== 0) begin n_err++; $display("FAIL rst_mid_no_rsp: got %0d want 0", rsp_cnt); end
    model_en = 1'b1;
    run_cmd(DEPP_OP_DWR, 8'h5E, 1'b0, 8'h00, 60);
    n_cmp++; if ({r_rsp_n, r_dstb_n} !== {32'd1, 32'd3}) begin n_err++; $display("FAIL rst_mid_recover: got rsp=%0d dstb=%0d want 1/3", r_rsp_n, r_dstb_n); end
    n_cmp++; if (r_strb_depp !== 8'h5E) begin n_err++; $display("FAIL rst_mid_recover_byte: got %h want 5e", r_strb_depp); end
  endtask

`ifdef DEPP_HOST_TIMEOUT_EN
  task automatic test_timeout;
    model_en = 1'b0; i_wait = 1'b0; i_depp = 8'h3D;
    run_cmd(DEPP_OP_DRD, 8'h00, 1'b0, 8'h00, 60);
    n_cmp++; if (r_dstb_n !== TMO) begin n_err++; $display("FAIL tmo_strobe_len: got %0d want %0d", r_dstb_n, TMO); end
    n_cmp++; if ({r_rsp_n, 31'd0, r_err} !== {32'd1, 32'd1}) begin n_err++; $display("FAIL tmo_rsp: got rsp=%0d err=%b want 1/1", r_rsp_n, r_err); end
    n_cmp++; if (o_rsp_data !== 8'h00) begin n_err++; $display("FAIL tmo_no_capture: got %h want 00", o_rsp_data); end
    @(negedge i_clk);
    n_cmp++; if ({o_astb_n, o_dstb_n, o_depp_oe, o_cmd_busy} !== 4'b1100) begin n_err++; $display("FAIL tmo_idle: got %b want 1100", {o_astb_n, o_dstb_n, o_depp_oe, o_cmd_busy}); end
    model_en = 1'b1;
  endtask
`else
  task automatic test_no_timeout;
    model_en = 1'b0; i_wait = 1'b0;
    run_cmd(DEPP_OP_AWR, 8'h42, 1'b0, 8'h00, 40);
    n_cmp++; if (r_rsp_n !== 0) begin n_err++; $display("FAIL notmo_rsp: got %0d want 0", r_rsp_n); end
    n_cmp++; if (r_astb_n !== 40 - SETUP) begin n_err++; $display("FAIL notmo_strobe_held: got %0d want %0d", r_astb_n, 40 - SETUP); end
    #2 i_rst = 1'b1;
    @(negedge i_clk); i_rst = 1'b0;
    model_en = 1'b1;
    @(negedge i_clk);
  endtask
`endif

  task automatic test_invariants;
    n_cmp++; if (viol_both !== 0) begin n_err++; $display("FAIL inv_one_strobe: got %0d violations want 0", viol_both); end
    n_cmp++; if (viol_oe !== 0) begin n_err++; $display("FAIL inv_oe_write_n: got %0d violations want 0", viol_oe); end
    n_cmp++; if (viol_entry !== 0) begin n_err++; $display("FAIL inv_strobe_entry_wait: got %0d violations want 0", viol_entry); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_addr_write();
    test_data_read();
    test_back_to_back();
    test_ignore_busy();
    test_wait_holdoff();
    test_reset_mid_strobe();
`ifdef DEPP_HOST_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
